// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - DDS phase accumulator with a 3-stage sample pipeline
// Enable steps the phase, stage 1 addresses the sine ROM, stage 2 selects the sample.
module dds_phase_gen #(
  parameter int              ACC_W   = 24,
  parameter int              OUT_W   = 8,
  parameter int              LUT_AW  = 8,
  parameter logic [ACC_W-1:0] FTW_RST = 24'h010000
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              Ready,
  input  logic              Enable,
  input  logic              FtwValid,
  input  logic [ACC_W-1:0]  FtwData,
  output logic              FtwReady,
  input  logic [1:0]        WaveSel,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [OUT_W-1:0]  LutData,
  output logic [OUT_W-1:0]  SampleOut,
  output logic              SampleValid
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_ftw_active;
  logic [ACC_W-1:0]   r_ftw_shadow;
  logic               r_pending;
  logic               r_v1;
  logic               r_v2;
  logic [1:0]         r_wsel1;
  logic [1:0]         r_wsel2;
  logic [OUT_W-1:0]   r_wave;
  logic [LUT_AW-1:0]  r_lut_addr;
  logic [OUT_W-1:0]   r_sample;
  logic               r_sample_valid;

  logic [ACC_W-1:0]   w_ftw_eff;
  logic               w_accept;
  logic [OUT_W-1:0]   w_wave;

  assign w_ftw_eff = r_pending ? r_ftw_shadow : r_ftw_active;
  assign w_accept  = FtwValid && !r_pending;

  // r_acc already holds the updated phase when stage 1 reads it.
  always_comb begin
    w_wave = '0;
    case (r_wsel1)
      2'd1:    w_wave = {OUT_W{r_acc[ACC_W-1]}};
      2'd2:    w_wave = r_acc[ACC_W-1 -: OUT_W];
      2'd3:    w_wave = r_acc[ACC_W-2 -: OUT_W] ^ {OUT_W{r_acc[ACC_W-1]}};
      default: w_wave = '0;
    endcase
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_ftw_active   <= FTW_RST;
      r_ftw_shadow   <= '0;
      r_pending      <= 1'b0;
      r_v1           <= 1'b0;
      r_v2           <= 1'b0;
      r_wsel1        <= 2'd0;
      r_wsel2        <= 2'd0;
      r_wave         <= '0;
      r_lut_addr     <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ftw_shadow <= FtwData;
        r_pending    <= 1'b1;
      end

      r_v2    <= r_v1;
      r_wsel2 <= r_wsel1;
      if (r_v1) begin
        r_lut_addr <= r_acc[ACC_W-1 -: LUT_AW];
        r_wave     <= w_wave;
      end

      // LutAddr is the ROM's address register, so LutData lines up with stage 2.
      r_sample_valid <= r_v2;
      if (r_v2)
        r_sample <= (r_wsel2 == 2'd0) ? LutData : r_wave;

      case (r_state)
        ST_IDLE: begin
          r_acc <= '0;
          r_v1  <= 1'b0;
          if (Ready)
            r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!Ready) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
          end else if (Enable) begin
            r_acc   <= r_acc + w_ftw_eff;
            r_v1    <= 1'b1;
            r_wsel1 <= WaveSel;
            if (r_pending) begin
              r_ftw_active <= r_ftw_shadow;
              r_pending    <= 1'b0;
            end
          end else begin
            r_v1 <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign FtwReady    = ~r_pending;
  assign LutAddr     = r_lut_addr;
  assign SampleOut   = r_sample;
  assign SampleValid = r_sample_valid;

endmodule
